key_scan_ctrl: RTL and testbench
================================

# key_scan_ctrl

Sequencer for the 16-bit latched keypad register. Synchronises the asynchronously set `key_reg` flags into the system clock domain and snapshots them into an internal pending mask. It drives `key_clear` to re-arm the latch, then emits one 4-bit key code per valid/ready handshake in fixed priority order. Sits between the keypad latch and the shopping-logic FSM, which only ever sees clean, single-occurrence key events.

## Interface
- `CLR_CYCLES`, default 4: minimum cycles `key_clear` is held high per clear sequence (legal range 1..15).
- `SYNC_STAGES`, default 2: flops in the input synchroniser (legal range ≥2).
- `clk`  in  1: system clock. One clock domain.
- `rst`  in  1: reset. Reset is synchronous and active-high.
- `key_reg`  in  16: latched key flags from the keypad latch; asynchronous to `clk`.
- `key_clear`  out  1: active-high clear request to the keypad latch.
- `key_code`  out  4: index of the emitted key.
- `key_valid`  out  1: `key_code` is valid.
- `key_ready`  in  1: consumer accepts the code.
- `busy`  out  1: high when the FSM is not in IDLE or the pending mask is non-zero.
- `key_dup`  out  1: one-cycle pulse when a snapshot merges a key that is already pending (see Configuration).

## Operation
- **Synchroniser:** `key_reg` passes through `SYNC_STAGES` flops, giving `ks[15:0]`.
- **Capture FSM:**
  - IDLE: if `ks != 0`, then `pending <= pending | ks`, counter is cleared, and the FSM goes to CLEAR.
  - CLEAR: `key_clear = 1` and the counter increments, saturating at 15. Exit to IDLE on the first edge where counter ≥ `CLR_CYCLES` and `ks == 0`; `key_clear` is low from that edge.
  - There is no other state.
- **Emission path:** runs independently of the FSM.
  - When `!key_valid || key_ready`: if `pending != 0`, load `key_code` with the lowest set index, set `key_valid`, and remove that bit from `pending`. Otherwise drop `key_valid`.
  - `key_valid` and `key_code` are stable while `key_valid && !key_ready`.
- **Pending update in one cycle:** `pending_next = (pending & ~taken) | snap`. A snapshot bit equal to the taken bit leaves it pending, so it is emitted again on a later handshake.
- **Duplicates:** a key pressed again while pending is merged; it is never emitted twice from one pending residence.
- **Latch race:** a key latched during CLEAR is lost by the latch clear. This is accepted behaviour, because the latch clear is global.
- **Reset values:** `key_clear` 0, `key_valid` 0, `key_code` 0, `busy` 0, `key_dup` 0, `pending` 0, FSM in IDLE, synchroniser 0.
- **Reset mid-operation:** all pending keys are dropped. Latch flags still set after reset are re-detected and re-captured normally.

## Timing
- `key_reg[i]` first sampled high at edge N:
  - `ks[i]` high after edge N+`SYNC_STAGES`−1.
  - `pending[i]` and `key_clear` set at edge N+`SYNC_STAGES`.
  - `key_valid` with `key_code = i` at edge N+`SYNC_STAGES`+1, if the emission path is idle.
- `key_clear` high for at least `CLR_CYCLES` cycles. It is extended while the synchronised view is non-zero (latch release plus `SYNC_STAGES`).
- Throughput: one code per cycle while `key_ready` is held high.
- Emission latency from pending to `key_valid` is 1 cycle.

## Configuration
- Macro: `KEY_SCAN_DUP_DET_EN`.
- **Defined:** `key_dup` pulses high for one cycle on the snapshot edge when `ks & pending_after_take != 0`.
- **Undefined:** `key_dup` is tied 0 and the compare logic is absent.
- All other behaviour is identical in both builds.

## Structure
- **Package `key_scan_pkg`:**
  - `KEY_W = 16`, `CODE_W = 4`.
  - State enum `scan_state_t {ST_IDLE, ST_CLEAR}`.
  - Lowest-set-bit priority function.
- **Sub-module `key_sync`:** parameterised `SYNC_STAGES` × `KEY_W` synchroniser with synchronous active-high reset. Instantiated once.

## Test plan
- **Single key:** `key_reg = 16'h0020` latched, `key_ready = 1`. Expect `key_valid` for 1 cycle with `key_code = 5`, `key_clear` high for 4 cycles, then `busy` falls.
- **Multiple keys:** `key_reg = 16'h8101` with `key_ready` held low 10 cycles, then high. Expect codes 0, 8, 15 on consecutive cycles, and a single clear sequence.
- **Backpressure:** `key_ready` toggled 1/0 during the three-key burst. `key_code` stays stable whenever `valid && !ready`, and no code is lost or repeated.
- **Duplicate:** key 3 pending and unaccepted, then key 3 latched again. Expect one emission of code 3, and a `key_dup` pulse only when `KEY_SCAN_DUP_DET_EN` is defined.
- **Slow latch release:** `key_reg` held non-zero for 8 cycles after `key_clear` rises. Expect `key_clear` to stay high until `ks == 0`, then the FSM returns to IDLE.
- **Reset mid-burst:** `rst` asserted with 2 keys pending. Next cycle `key_valid = 0`, `key_clear = 0`, `busy = 0`. After release, a still-latched key is re-captured and emitted.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared widths, capture-FSM state encoding and the key priority encoder
// used by the keypad scan sequencer.
package key_scan_pkg;

    localparam int KEY_W  = 16;
    localparam int CODE_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } scan_state_t;

    // Lowest set index wins; returns 0 for an empty vector.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Multi-flop synchroniser for the asynchronous keypad latch flags.
// Latency SYNC_STAGES cycles; no backpressure (free-running).
module key_sync
    import key_scan_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] d_i,
    output logic [KEY_W-1:0] q_o
);

    logic [KEY_W-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_scan_ctrl.sv
// Keypad latch sequencer: sync + snapshot + clear, then one code per valid/ready beat;
// pending->valid in 1 cycle, code held while stalled. KEY_SCAN_DUP_DET_EN enables key_dup.
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter int CLR_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEY_W-1:0]  key_reg_i,
    output logic              key_clear_o,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    input  logic              key_ready_i,
    output logic              busy_o,
    output logic              key_dup_o
);

    localparam logic [3:0] CLR_LIM = 4'(CLR_CYCLES);

    logic [KEY_W-1:0]  ks;
    scan_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [KEY_W-1:0]  pending_q, pending_d;
    logic [KEY_W-1:0]  snap;
    logic [KEY_W-1:0]  taken;
    logic [KEY_W-1:0]  pending_after;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;

    key_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (key_reg_i),
        .q_o   (ks)
    );

    // Capture FSM: snapshot on detection, then hold the latch clear until it
    // has lasted long enough and the synchronised view has drained.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (ks != '0) begin
                    snap    = ks;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                if ((cnt_d >= CLR_LIM) && (ks == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Emission path, independent of the capture FSM.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        taken   = '0;
        if (!valid_q || key_ready_i) begin
            if (pending_q != '0) begin
                code_d  = lowest_set(pending_q);
                valid_d = 1'b1;
                taken   = {{(KEY_W-1){1'b0}}, 1'b1} << code_d;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // A re-snapshot of the bit being taken this cycle keeps it pending.
    assign pending_after = pending_q & ~taken;
    assign pending_d     = pending_after | snap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
        end
    end

`ifdef KEY_SCAN_DUP_DET_EN
    logic dup_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dup_q <= 1'b0;
        end else begin
            dup_q <= |(snap & pending_after);
        end
    end

    assign key_dup_o = dup_q;
`else
    assign key_dup_o = 1'b0;
`endif

    assign key_clear_o = (state_q == ST_CLEAR);
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;
    assign busy_o      = (state_q != ST_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: scoreboard of expected key codes,
// a behavioural keypad latch, and one task per scenario.
module tb_key_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_reg;
    logic        key_ready;
    logic        hold;
    logic        key_clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        busy;
    logic        key_dup;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

`ifdef KEY_SCAN_DUP_DET_EN
    localparam int DUP_EXP = 1;
`else
    localparam int DUP_EXP = 0;
`endif

    always #5 clk = ~clk;

    key_scan_ctrl #(
        .CLR_CYCLES  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_reg_i   (key_reg),
        .key_clear_o (key_clear),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_ready_i (key_ready),
        .busy_o      (busy),
        .key_dup_o   (key_dup)
    );

    // One clock step; the keypad latch empties while key_clear is high unless held.
    task automatic tick();
        @(posedge clk);
        #1;
        if (key_clear && !hold) key_reg = '0;
    endtask

    task automatic wait_quiet(input int lim, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < lim) begin
            if (!busy && !key_valid && !key_clear) ok = 1'b1;
            else begin
                tick();
                i++;
            end
        end
    endtask

    task automatic monitor_handshakes();
        bit       stall_prev;
        logic [3:0] code_prev;
        int       e;
        stall_prev = 1'b0;
        code_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    n_checks++;
                    if (key_valid !== 1'b1 || key_code !== code_prev) begin
                        n_fail++;
                        $display("FAIL hold_stable: valid=%b code=%0d, required valid=1 code=%0d",
                                 key_valid, key_code, code_prev);
                    end
                end
                if (key_valid === 1'b1 && key_ready === 1'b1) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: code=%0d emitted, required no emission", key_code);
                    end else begin
                        e = exp_q.pop_front();
                        if (key_code !== 4'(e)) begin
                            n_fail++;
                            $display("FAIL sb_code: code=%0d, required %0d", key_code, e);
                        end
                    end
                end
                stall_prev = key_valid && !key_ready;
                code_prev  = key_code;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_reg = '0; key_ready = 1'b0; hold = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (key_clear !== 1'b0) begin n_fail++; $display("FAIL rst_clear: %b, required 0", key_clear); end
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: %b, required 0", key_valid); end
        n_checks++;
        if (key_code !== 4'd0) begin n_fail++; $display("FAIL rst_code: %0d, required 0", key_code); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b, required 0", busy); end
        n_checks++;
        if (key_dup !== 1'b0) begin n_fail++; $display("FAIL rst_dup: %b, required 0", key_dup); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_key();
        int clr_first, clr_cnt, vld_first, vld_cnt, busy_fall;
        logic [3:0] vld_code;
        clr_first = -1; clr_cnt = 0; vld_first = -1; vld_cnt = 0; busy_fall = -1; vld_code = '0;
        key_ready = 1'b1;
        tick();
        key_reg = 16'h0020;
        exp_q.push_back(5);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (key_clear) begin
                if (clr_first < 0) clr_first = k;
                clr_cnt++;
            end
            if (key_valid) begin
                if (vld_first < 0) vld_first = k;
                vld_cnt++;
                vld_code = key_code;
            end
            if (busy_fall < 0 && clr_first >= 0 && !busy) busy_fall = k;
        end
        n_checks++;
        if (clr_first != 3) begin n_fail++; $display("FAIL single_clr_rise: cycle %0d, required 3", clr_first); end
        n_checks++;
        if (clr_cnt != 4) begin n_fail++; $display("FAIL single_clr_len: %0d cycles, required 4", clr_cnt); end
        n_checks++;
        if (vld_first != 4) begin n_fail++; $display("FAIL single_vld_rise: cycle %0d, required 4", vld_first); end
        n_checks++;
        if (vld_cnt != 1) begin n_fail++; $display("FAIL single_vld_len: %0d cycles, required 1", vld_cnt); end
        n_checks++;
        if (vld_code !== 4'd5) begin n_fail++; $display("FAIL single_code: %0d, required 5", vld_code); end
        n_checks++;
        if (busy_fall != 7) begin n_fail++; $display("FAIL single_busy_fall: cycle %0d, required 7", busy_fall); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_multi_keys();
        int  rises;
        bit  clr_prev, ok;
        logic [5:0] vpat;
        rises = 0; clr_prev = 1'b0; vpat = '0;
        key_ready = 1'b0;
        tick();
        key_reg = 16'h8101;
        exp_q.push_back(0); exp_q.push_back(8); exp_q.push_back(15);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (key_clear && !clr_prev) rises++;
            clr_prev = key_clear;
        end
        key_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vpat[k] = key_valid;
            tick();
            if (key_clear && !clr_prev) rises++;
            clr_prev = key_clear;
        end
        wait_quiet(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL multi_timeout: not idle, required idle within 20 cycles"); end
        n_checks++;
        if (vpat !== 6'b000111) begin n_fail++; $display("FAIL multi_valid_run: %b, required 000111", vpat); end
        n_checks++;
        if (rises != 1) begin n_fail++; $display("FAIL multi_clear_seqs: %0d, required 1", rises); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL multi_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        key_ready = 1'b0;
        tick();
        key_reg = 16'h0124;
        exp_q.push_back(2); exp_q.push_back(5); exp_q.push_back(8);
        for (int k = 1; k <= 20; k++) begin
            key_ready = (k % 2 == 1);
            tick();
        end
        key_ready = 1'b1;
        wait_quiet(30, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_timeout: not idle, required idle within 30 cycles"); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_duplicate();
        int dups;
        bit ok;
        dups = 0;
        key_ready = 1'b0;
        tick();
        key_reg = 16'h000A;
        exp_q.push_back(1); exp_q.push_back(3);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (key_dup) dups++;
        end
        key_reg = 16'h0008;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (key_dup) dups++;
        end
        key_ready = 1'b1;
        wait_quiet(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dup_timeout: not idle, required idle within 20 cycles"); end
        n_checks++;
        if (dups != DUP_EXP) begin n_fail++; $display("FAIL dup_pulses: %0d, required %0d", dups, DUP_EXP); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL dup_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_slow_release();
        int drops, k;
        bit seen;
        logic [2:0] cpat;
        drops = 0; seen = 1'b0; cpat = '0;
        key_ready = 1'b1;
        hold = 1'b1;
        tick();
        key_reg = 16'h0040;
        exp_q.push_back(6);
        k = 0;
        while (!seen && k < 10) begin
            tick();
            k++;
            seen = key_clear;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL slow_clr_rise: clear=0, required 1 within 10 cycles"); end
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (!key_clear) drops++;
        end
        key_reg = '0;
        hold = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            cpat[j] = key_clear;
        end
        n_checks++;
        if (drops != 0) begin n_fail++; $display("FAIL slow_clr_held: dropped %0d cycles, required 0", drops); end
        n_checks++;
        if (cpat !== 3'b011) begin n_fail++; $display("FAIL slow_clr_tail: %b, required 011", cpat); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL slow_busy: %b, required 0", busy); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL slow_drain: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        int k;
        bit seen, ok;
        seen = 1'b0;
        key_ready = 1'b0;
        hold = 1'b1;
        tick();
        key_reg = 16'h0003;
        k = 0;
        while (!seen && k < 10) begin
            tick();
            k++;
            seen = key_valid;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rmb_valid: valid=0, required 1 within 10 cycles"); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_valid_rst: %b, required 0", key_valid); end
        n_checks++;
        if (key_clear !== 1'b0) begin n_fail++; $display("FAIL rmb_clear_rst: %b, required 0", key_clear); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmb_busy_rst: %b, required 0", busy); end
        rst = 1'b0;
        hold = 1'b0;
        key_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
        repeat (4) tick();
        wait_quiet(30, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rmb_timeout: not idle, required idle within 30 cycles"); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rmb_drain: %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; key_reg = '0; key_ready = 1'b0; hold = 1'b0;
        fork
            monitor_handshakes();
        join_none
        test_reset();
        test_single_key();
        test_multi_keys();
        test_backpressure();
        test_duplicate();
        test_slow_release();
        test_reset_mid_burst();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
